// File: rtl/line_scan_sequencer_if.sv
// Select/handshake bundle between a scan requester and line_scan_sequencer.
// The sequencer uses the slave modport; the requester uses master.
interface line_scan_sequencer_if #(
  parameter int unsigned DWELL_W = 4
);
  logic               START;
  logic               STOP;
  logic               CONT;
  logic [3:0]         MASK;
  logic [DWELL_W-1:0] DWELL;
  logic               EN;
  logic               A0;
  logic               A1;
  logic               BUSY;
  logic               DONE;

  modport master (
    output START, STOP, CONT, MASK, DWELL,
    input  EN, A0, A1, BUSY, DONE
  );

  modport slave (
    input  START, STOP, CONT, MASK, DWELL,
    output EN, A0, A1, BUSY, DONE
  );
endinterface

// File: rtl/line_scan_sequencer.sv
// Steps the 2-to-4 line decoder select (EN/A1/A0) through a masked set of lines.
// Define LINE_SCAN_GAP_EN for a break-before-make GAP cycle at each line boundary.
module line_scan_sequencer #(
  parameter int unsigned DWELL_W = 4
) (
  input logic                  CLK,
  input logic                  RST,
  line_scan_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
`ifdef LINE_SCAN_GAP_EN
  localparam logic [1:0] GAP  = 2'd2;
`endif
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]         state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic [3:0]         mask_q;
  logic               cont_q;
  logic               en;
  logic [1:0]         addr;
  logic               busy;
  logic               done;

  logic [3:0]         higher;
  logic               has_higher;
  logic [1:0]         next_higher;
  logic [1:0]         first_q;
  logic [1:0]         first_in;

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    logic [1:0] r;
    casez (m)
      4'b???1: r = 2'd0;
      4'b??10: r = 2'd1;
      4'b?100: r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  // Lines above the current one still enabled in the latched mask.
  always_comb begin
    higher      = mask_q & (4'b1110 << addr);
    has_higher  = |higher;
    next_higher = lowest_bit(higher);
    first_q     = lowest_bit(mask_q);
    first_in    = lowest_bit(bus.MASK);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
      en      <= 1'b0;
      addr    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START && !bus.STOP && (bus.MASK != 4'b0000)) begin
            mask_q  <= bus.MASK;
            cont_q  <= bus.CONT;
            dwell_q <= bus.DWELL;
            addr    <= first_in;
            cnt     <= '0;
            en      <= 1'b1;
            busy    <= 1'b1;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (bus.STOP) begin
            state <= IDLE;
            en    <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt == dwell_q) begin
            cnt <= '0;
            if (has_higher || cont_q) begin
              addr <= has_higher ? next_higher : first_q;
`ifdef LINE_SCAN_GAP_EN
              // Address moves during the gap so the decoder sees it settled before EN.
              state <= GAP;
              en    <= 1'b0;
`endif
            end else begin
              state <= FIN;
              en    <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef LINE_SCAN_GAP_EN
        GAP: begin
          if (bus.STOP) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= SCAN;
            en    <= 1'b1;
          end
        end
`endif
        FIN: state <= IDLE;
        default: begin
          state <= IDLE;
          en    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.EN   = en;
  assign bus.A0   = addr[0];
  assign bus.A1   = addr[1];
  assign bus.BUSY = busy;
  assign bus.DONE = done;

endmodule

// File: tb/tb_line_scan_sequencer.sv
// Directed bench for line_scan_sequencer: vector table plus reset/max-dwell sequences.
module tb_line_scan_sequencer;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int failures = 0;

  line_scan_sequencer_if #(.DWELL_W(4)) bus ();

  line_scan_sequencer #(.DWELL_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       start;
    logic       stop;
    logic       cont;
    logic [3:0] mask;
    logic [3:0] dwell;
    logic [4:0] exp;   // {EN, A1, A0, BUSY, DONE}
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [4:0] outs();
    return {bus.EN, bus.A1, bus.A0, bus.BUSY, bus.DONE};
  endfunction

  task automatic check5(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {EN,A1,A0,BUSY,DONE}=%b required %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic c, input logic [3:0] m,
                     input logic [3:0] d, input logic [4:0] e, input string n);
    vec_t v;
    v.start = st; v.stop = sp; v.cont = c; v.mask = m; v.dwell = d; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic sp, input logic c, input logic [3:0] m,
                       input logic [3:0] d);
    bus.START = st; bus.STOP = sp; bus.CONT = c; bus.MASK = m; bus.DWELL = d;
  endtask

  initial begin
    int en_cycles;
    int busy_cycles;
    int done_seen;
    int en_after_done;

    drive(1'b0, 1'b0, 1'b0, 4'b0000, 4'h0);
    #3;
    check5("reset_state", outs(), 5'b00000);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;

    // Ignored requests straight out of reset
    add(1, 0, 0, 4'b0000, 4'h1, 5'b00000, "start_mask0");
    add(0, 0, 0, 4'b0000, 4'h1, 5'b00000, "start_mask0_idle");
    add(1, 1, 1, 4'b1111, 4'h1, 5'b00000, "start_and_stop");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b00000, "start_and_stop_idle");
`ifndef LINE_SCAN_GAP_EN
    // Single frame 1011, DWELL=1; START/MASK changes mid-frame must be ignored
    add(1, 0, 0, 4'b1011, 4'h1, 5'b10010, "frame_l0_c0");
    add(1, 0, 1, 4'b0100, 4'h7, 5'b10010, "frame_l0_c1");
    add(1, 0, 1, 4'b0100, 4'h7, 5'b10110, "frame_l1_c0");
    add(0, 0, 0, 4'b0100, 4'h0, 5'b10110, "frame_l1_c1");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b11110, "frame_l3_c0");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b11110, "frame_l3_c1");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b01101, "frame_done");
    add(1, 1, 0, 4'b1111, 4'h0, 5'b01100, "frame_idle_stop_in_fin");
    // Continuous 1001, DWELL=0, then STOP
    add(1, 0, 1, 4'b1001, 4'h0, 5'b10010, "wrap_a0");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b11110, "wrap_a3");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b10010, "wrap_a0_again");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b11110, "wrap_a3_again");
    add(0, 1, 0, 4'b0000, 4'h0, 5'b01100, "wrap_stop");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b01100, "wrap_stop_idle");
    // Single-bit continuous holds line 2
    add(1, 0, 1, 4'b0100, 4'h0, 5'b11010, "single_hold_0");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b11010, "single_hold_1");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b11010, "single_hold_2");
    add(0, 1, 0, 4'b0000, 4'h0, 5'b01000, "single_stop");
`else
    // Gap frame 0110, DWELL=2
    add(1, 0, 0, 4'b0110, 4'h2, 5'b10110, "gap_l1_c0");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b10110, "gap_l1_c1");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b10110, "gap_l1_c2");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b01010, "gap_cycle");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b11010, "gap_l2_c0");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b11010, "gap_l2_c1");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b11010, "gap_l2_c2");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b01001, "gap_done");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b01000, "gap_idle");
    // Single-bit continuous: gap on same-line wrap
    add(1, 0, 1, 4'b0100, 4'h0, 5'b11010, "gap_single_0");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b01010, "gap_single_gap");
    add(0, 0, 0, 4'b0000, 4'h0, 5'b11010, "gap_single_1");
    add(0, 1, 0, 4'b0000, 4'h0, 5'b01000, "gap_single_stop");
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].cont, vecs[i].mask, vecs[i].dwell);
      @(posedge CLK); #1;
      check5(vecs[i].name, outs(), vecs[i].exp);
    end

    // Maximum dwell, single line, single frame
    drive(1'b1, 1'b0, 1'b0, 4'b0001, 4'hF);
    en_cycles = 0; busy_cycles = 0; done_seen = 0; en_after_done = 0;
    for (int unsigned c = 0; c < 40; c++) begin
      @(posedge CLK); #1;
      drive(1'b0, 1'b0, 1'b0, 4'b0000, 4'h0);
      if (done_seen != 0 && bus.EN) en_after_done++;
      if (bus.EN) en_cycles++;
      if (bus.BUSY) busy_cycles++;
      if (bus.DONE) done_seen++;
    end
    check_int("maxdwell_en_cycles", en_cycles, 16);
    check_int("maxdwell_busy_cycles", busy_cycles, 16);
    check_int("maxdwell_done_pulses", done_seen, 1);
    check_int("maxdwell_en_after_done", en_after_done, 0);

    // Asynchronous reset mid-scan on line 2
    drive(1'b1, 1'b0, 1'b1, 4'b0100, 4'h3);
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 4'h0);
    check5("pre_reset_scan", outs(), 5'b11010);
    #2;
    RST = 1'b1;
    #1;
    check5("async_reset", outs(), 5'b00000);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    check5("post_reset_idle", outs(), 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
